// File: rtl/piso_feeder_pkg.sv
// Shared helpers for the PISO feeder slice.
package piso_feeder_pkg;

  // Pointer width for a power-of-two FIFO; a single-entry FIFO still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/piso_feeder_sync_fifo.sv
// First-word-fall-through synchronous FIFO buffering words for the PISO feeder.
module sync_fifo
  import piso_feeder_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so the head never carries X into the controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/piso_feeder.sv
// Feeds buffered parallel words into a PISO shifter and tags each serial bit with valid/last.
module piso_feeder
  import piso_feeder_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             piso_load_en,
  output logic             piso_shift_en,
  output logic [WIDTH-1:0] piso_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             consume;
  logic             at_last;
  logic             load;
  logic             shift;
  logic             push;

  assign at_last = active && (cnt == LAST_BIT);
  assign consume = active && out_ready;
  // A new word loads when the shifter is idle or its last bit leaves this cycle.
  assign load    = (!active || (consume && at_last)) && !fifo_empty;
  assign shift   = consume && !at_last;
  assign push    = in_valid && !fifo_full;

  sync_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (load),
    .din   (in_data),
    .dout  (piso_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (consume && at_last) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (shift) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign piso_load_en  = load;
  assign piso_shift_en = shift;
  assign out_valid     = active;
  assign out_last      = at_last;
  assign in_ready      = !fifo_full;
  assign busy          = active || !fifo_empty;

endmodule

// File: tb/tb_piso_feeder.sv
// Self-checking bench: queue-based reference model plus a behavioural shifter driven by the DUT enables.
module tb_piso_feeder;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             piso_load_en;
  logic             piso_shift_en;
  logic [WIDTH-1:0] piso_data;
  logic             out_valid;
  logic             out_last;
  logic             busy;

  always #5 clk = ~clk;

  piso_feeder #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .piso_load_en  (piso_load_en),
    .piso_shift_en (piso_shift_en),
    .piso_data     (piso_data),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .busy          (busy)
  );

  // Shifter alongside the feeder: load captures the word, shift exposes the next lower bit.
  logic [WIDTH-1:0] sreg;
  logic             serial_out;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sreg <= '0;
    else if (piso_load_en) sreg <= piso_data;
    else if (piso_shift_en) sreg <= {sreg[WIDTH-2:0], 1'b0};
  end
  assign serial_out = sreg[WIDTH-1];

  int n_checks = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] m_fifo[$];
  bit               m_bits[$];
  bit               got[$];
  logic e_valid, e_last, e_load, e_shift, e_ready, e_busy, e_bit;

  // Reference: words waiting in a queue, the current word as a queue of remaining bits (MSB first).
  task automatic model_eval();
    e_valid = (m_bits.size() > 0);
    e_last  = (m_bits.size() == 1);
    e_bit   = e_valid ? m_bits[0] : 1'b0;
    e_ready = (m_fifo.size() < DEPTH);
    e_load  = ((m_bits.size() == 0) || (out_ready && m_bits.size() == 1)) && (m_fifo.size() > 0);
    e_shift = out_ready && (m_bits.size() > 1);
    e_busy  = e_valid || (m_fifo.size() > 0);
  endtask

  task automatic tick();
    logic [WIDTH-1:0] w;
    model_eval();
    if (out_valid && out_ready) got.push_back(serial_out);
    @(posedge clk);
    if (e_valid && out_ready) void'(m_bits.pop_front());
    if (e_load) begin
      w = m_fifo.pop_front();
      for (int i = WIDTH - 1; i >= 0; i--) m_bits.push_back(w[i]);
    end
    if (in_valid && e_ready) m_fifo.push_back(in_data);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    m_fifo.delete();
    m_bits.delete();
    got.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy} !== 6'b000010) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: got %b exp 000010", {out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy});
    end
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++;
      if ({out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy} !== 6'b000010) begin
        n_fail++;
        $display("[TB] FAIL reset_idle cyc %0d: got %b exp 000010", c, {out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy});
      end
      tick();
    end
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] v;
    got.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'b1011;
    for (int c = 0; c < 9; c++) begin
      #1;
      model_eval();
      if (c == 1) begin
        n_checks++;
        if (piso_load_en !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL single_load_latency: got %b exp 1", piso_load_en);
        end
      end
      n_checks++;
      if ({out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy} !== {e_valid, e_last, e_load, e_shift, e_ready, e_busy}) begin
        n_fail++;
        $display("[TB] FAIL single_ctl cyc %0d: got %b exp %b", c, {out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy}, {e_valid, e_last, e_load, e_shift, e_ready, e_busy});
      end
      if (e_valid) begin
        n_checks++;
        if (serial_out !== e_bit) begin
          n_fail++;
          $display("[TB] FAIL single_bit cyc %0d: got %b exp %b", c, serial_out, e_bit);
        end
      end
      tick();
      in_valid = 1'b0;
    end
    v = '0;
    foreach (got[i]) v = {v[WIDTH-2:0], got[i]};
    n_checks++;
    if (got.size() != 4 || v !== 4'b1011 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_stream: got %0d bits %b busy %b exp 4 bits 1011 busy 0", got.size(), v, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] words [3];
    logic [11:0] v;
    int idx = 0;
    int run = 0;
    int max_run = 0;
    words[0] = 4'hA;
    words[1] = 4'h5;
    words[2] = 4'hF;
    got.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (idx < 3);
      in_data  = (idx < 3) ? words[idx] : 4'h0;
      #1;
      model_eval();
      n_checks++;
      if ({out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy} !== {e_valid, e_last, e_load, e_shift, e_ready, e_busy}) begin
        n_fail++;
        $display("[TB] FAIL b2b_ctl cyc %0d: got %b exp %b", c, {out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy}, {e_valid, e_last, e_load, e_shift, e_ready, e_busy});
      end
      if (e_valid) begin
        n_checks++;
        if (serial_out !== e_bit) begin
          n_fail++;
          $display("[TB] FAIL b2b_bit cyc %0d: got %b exp %b", c, serial_out, e_bit);
        end
      end
      run = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (in_valid && e_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    v = '0;
    foreach (got[i]) v = {v[10:0], got[i]};
    n_checks++;
    if (got.size() != 12 || v !== 12'hA5F || max_run != 12) begin
      n_fail++;
      $display("[TB] FAIL b2b_stream: got %0d bits %h run %0d exp 12 bits a5f run 12", got.size(), v, max_run);
    end
  endtask

  task automatic test_backpressure();
    logic [6:0]       pat = 7'b1001101;
    logic [WIDTH-1:0] v;
    got.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'b1100;
    for (int c = 0; c < 12; c++) begin
      if (c >= 2 && c <= 8) out_ready = pat[8 - c];
      else out_ready = 1'b1;
      #1;
      model_eval();
      n_checks++;
      if ({out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy} !== {e_valid, e_last, e_load, e_shift, e_ready, e_busy}) begin
        n_fail++;
        $display("[TB] FAIL bp_ctl cyc %0d: got %b exp %b", c, {out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy}, {e_valid, e_last, e_load, e_shift, e_ready, e_busy});
      end
      if (e_valid) begin
        n_checks++;
        if (serial_out !== e_bit) begin
          n_fail++;
          $display("[TB] FAIL bp_bit cyc %0d: got %b exp %b", c, serial_out, e_bit);
        end
      end
      n_checks++;
      if ((piso_load_en && piso_shift_en) || (piso_shift_en && !(out_valid && out_ready))) begin
        n_fail++;
        $display("[TB] FAIL bp_enables cyc %0d: got load %b shift %b exp shift only on consume", c, piso_load_en, piso_shift_en);
      end
      tick();
      in_valid = 1'b0;
    end
    v = '0;
    foreach (got[i]) v = {v[WIDTH-2:0], got[i]};
    n_checks++;
    if (got.size() != 4 || v !== 4'b1100) begin
      n_fail++;
      $display("[TB] FAIL bp_stream: got %0d bits %b exp 4 bits 1100", got.size(), v);
    end
  endtask

  task automatic test_full();
    logic [WIDTH-1:0] words [4];
    logic [15:0] v;
    logic [15:0] exp_v;
    int idx = 0;
    exp_v = '0;
    for (int i = 0; i < 4; i++) begin
      words[i] = WIDTH'($urandom);
      exp_v = {exp_v[11:0], words[i]};
    end
    got.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 34; c++) begin
      in_valid  = (idx < 4);
      in_data   = (idx < 4) ? words[idx] : 4'h0;
      out_ready = (c >= 6);
      #1;
      model_eval();
      if (c == 5) begin
        n_checks++;
        if (in_ready !== 1'b0 || idx != 3) begin
          n_fail++;
          $display("[TB] FAIL full_in_ready: got in_ready %b accepted %0d exp 0 and 3", in_ready, idx);
        end
      end
      n_checks++;
      if ({out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy} !== {e_valid, e_last, e_load, e_shift, e_ready, e_busy}) begin
        n_fail++;
        $display("[TB] FAIL full_ctl cyc %0d: got %b exp %b", c, {out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy}, {e_valid, e_last, e_load, e_shift, e_ready, e_busy});
      end
      if (in_valid && e_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    v = '0;
    foreach (got[i]) v = {v[14:0], got[i]};
    n_checks++;
    if (got.size() != 16 || v !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL full_stream: got %0d bits %h exp 16 bits %h", got.size(), v, exp_v);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = (c < 2);
      in_data  = (c == 0) ? 4'b0110 : 4'h9;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy} !== 6'b000010) begin
      n_fail++;
      $display("[TB] FAIL midreset_async: got %b exp 000010", {out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy});
    end
    m_fifo.delete();
    m_bits.delete();
    got.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      #1;
      model_eval();
      n_checks++;
      if ({out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy} !== 6'b000010) begin
        n_fail++;
        $display("[TB] FAIL midreset_after cyc %0d: got %b exp 000010", c, {out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy});
      end
      tick();
    end
    n_checks++;
    if (got.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL midreset_stale: got %0d bits exp 0", got.size());
    end
  endtask

  task automatic test_random();
    int sent = 0;
    for (int c = 0; c < 460; c++) begin
      in_valid  = (c < 420) && ($urandom_range(0, 2) != 0);
      in_data   = WIDTH'($urandom);
      out_ready = (c >= 420) || ($urandom_range(0, 3) != 0);
      #1;
      model_eval();
      n_checks++;
      if ({out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy} !== {e_valid, e_last, e_load, e_shift, e_ready, e_busy}) begin
        n_fail++;
        $display("[TB] FAIL rand_ctl cyc %0d: got %b exp %b", c, {out_valid, out_last, piso_load_en, piso_shift_en, in_ready, busy}, {e_valid, e_last, e_load, e_shift, e_ready, e_busy});
      end
      if (e_valid) begin
        n_checks++;
        if (serial_out !== e_bit) begin
          n_fail++;
          $display("[TB] FAIL rand_bit cyc %0d: got %b exp %b", c, serial_out, e_bit);
        end
      end
      if (m_fifo.size() > 0) begin
        n_checks++;
        if (piso_data !== m_fifo[0]) begin
          n_fail++;
          $display("[TB] FAIL rand_head cyc %0d: got %h exp %h", c, piso_data, m_fifo[0]);
        end
      end
      if (in_valid && e_ready) sent++;
      tick();
    end
    n_checks++;
    if (busy !== 1'b0 || m_bits.size() != 0 || sent == 0) begin
      n_fail++;
      $display("[TB] FAIL rand_drain: got busy %b bits left %0d words %0d exp busy 0 and drained", busy, m_bits.size(), sent);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion exp finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
